// File: rtl/f0_pkg.sv
// Shared constants and writer state encoding for the pitch-estimation front end.
package f0_pkg;
  localparam int SAMPLE_W   = 12;
  localparam int ADDR_W     = 11;
  localparam int FRAME_LEN  = 2048;
  localparam int DEC_W      = 8;
  localparam int TMO_CYCLES = 8;
  localparam int TMO_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } wr_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/sample_frame_writer.sv
// Captures decimated ADC samples into the estimator frame buffer and runs the
// start/done handshake with the pitch estimator once a frame is complete.
module sample_frame_writer
  import f0_pkg::*;
#(
  parameter int DECIM     = 1,
  parameter int FRAME_LEN = f0_pkg::FRAME_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                we,
  output logic [ADDR_W-1:0]   waddr,
  output logic [SAMPLE_W-1:0] wdata,
  output logic                est_start,
  input  logic                est_done,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         dropped
);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIM - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_CYCLES - 1);

  // Async assert, synchronous release so every flop leaves reset on one edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  wr_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DEC_W-1:0]    dec_q, dec_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [SAMPLE_W-1:0] wdata_q, wdata_d;
  logic                est_start_q;
  logic                busy_q;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                drop_inc;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dec_d       = dec_q;
    tmo_d       = tmo_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_FILL;
          addr_d  = '0;
          dec_d   = '0;
        end
      end
      ST_FILL: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (sample_valid) begin
          dec_d = (dec_q == DEC_LAST) ? '0 : dec_q + 1'b1;
          if (dec_q == '0) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = sample_data;
            addr_d  = addr_q + 1'b1;
            if (addr_q == LAST_ADDR) state_d = ST_START;
          end
        end
      end
      ST_START: begin
        tmo_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // Estimator never went busy: retry the start pulse.
        if (!est_done)               state_d = ST_WAIT_DONE;
        else if (tmo_q == TMO_LAST)  state_d = ST_START;
        else                         tmo_d   = tmo_q + 1'b1;
      end
      ST_WAIT_DONE: begin
        if (est_done) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (enable) begin
            state_d = ST_FILL;
            addr_d  = '0;
            dec_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign drop_inc = sample_valid && enable &&
                    (state_q inside {ST_START, ST_WAIT_BUSY, ST_WAIT_DONE});

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      dec_q       <= '0;
      tmo_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      est_start_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dec_q       <= dec_d;
      tmo_q       <= tmo_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      est_start_q <= (state_q == ST_START);
      busy_q      <= (state_d != ST_IDLE);
      frame_cnt_q <= frame_cnt_d;
    end
  end

  sat_counter #(.WIDTH(16)) u_dropped (
    .clk     (clk),
    .rst_n   (rst_int_n),
    .inc_i   (drop_inc),
    .count_o (dropped)
  );

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign est_start = est_start_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_sample_frame_writer.sv
// Scoreboard bench for sample_frame_writer (DECIM=1 and DECIM=4 instances).
module tb_sample_frame_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0, sample_valid = 1'b0;
  logic [11:0] sample_data = '0;
  logic        est_done = 1'b1;
  logic        we, est_start, busy;
  logic [10:0] waddr;
  logic [11:0] wdata;
  logic [15:0] frame_cnt, dropped;

  logic        en4 = 1'b0, v4 = 1'b0;
  logic [11:0] d4 = '0;
  logic        est_done4 = 1'b1;
  logic        we4, est_start4, busy4;
  logic [10:0] waddr4;
  logic [11:0] wdata4;
  logic [15:0] frame_cnt4, dropped4;

  int checks = 0, failures = 0;
  int cyc = 0, last_wr_cyc = 0, est_mode = 0, busy_len = 100;
  int sent, d0, f0;
  logic [22:0] exp_q[$], obs_q[$], exp4_q[$], obs4_q[$];
  int est_q[$], est4_q[$];
  logic [22:0] e, o;

  always #5 clk = ~clk;

  sample_frame_writer #(.DECIM(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .we(we), .waddr(waddr), .wdata(wdata),
    .est_start(est_start), .est_done(est_done), .busy(busy),
    .frame_cnt(frame_cnt), .dropped(dropped));

  sample_frame_writer #(.DECIM(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(en4), .sample_valid(v4),
    .sample_data(d4), .we(we4), .waddr(waddr4), .wdata(wdata4),
    .est_start(est_start4), .est_done(est_done4), .busy(busy4),
    .frame_cnt(frame_cnt4), .dropped(dropped4));

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: collects observed writes and start pulses.
  always @(negedge clk) begin
    if (we) begin
      obs_q.push_back({waddr, wdata});
      if (waddr == 11'd2047) last_wr_cyc = cyc;
    end
    if (est_start) est_q.push_back(cyc);
    if (we4) obs4_q.push_back({waddr4, wdata4});
    if (est_start4) est4_q.push_back(cyc);
  end

  // Estimator model: goes busy 2 cycles after start, done busy_len cycles later.
  always begin
    @(negedge clk);
    if (est_start && est_mode == 0) begin
      repeat (2) @(posedge clk);
      #1 est_done = 1'b0;
      repeat (busy_len) @(posedge clk);
      #1 est_done = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_frame();
    for (int i = 0; i < 2048; i++) begin
      sample_valid = 1'b1;
      sample_data  = i[11:0];
      exp_q.push_back({i[10:0], i[11:0]});
      step();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({we, waddr, wdata, est_start, busy, frame_cnt, dropped} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {we, waddr, wdata, est_start, busy, frame_cnt, dropped});
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
  endtask

  task automatic test_frame_decim1();
    exp_q.delete(); obs_q.delete(); est_q.delete(); est_mode = 0;
    enable = 1'b1; step(); step();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL fill1_busy got=%b exp=1", busy); end
    fill_frame();
    sent = 0;
    for (int k = 0; k < 400 && frame_cnt != 16'd1; k++) begin
      sample_valid = 1'b1; sample_data = 12'hFFF; sent++; step();
    end
    sample_valid = 1'b0;
    checks++;
    if (frame_cnt !== 16'd1) begin failures++; $display("FAIL fill1_frame_cnt got=%0d exp=1", frame_cnt); end
    checks++;
    if (dropped !== 16'(sent)) begin failures++; $display("FAIL fill1_dropped got=%0d exp=%0d", dropped, sent); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL fill1_refill_busy got=%b exp=1", busy); end
    checks++;
    if (est_q.size() != 1) begin failures++; $display("FAIL fill1_est_start_count got=%0d exp=1", est_q.size()); end
    else begin
      checks++;
      if (est_q[0] != last_wr_cyc + 1) begin
        failures++; $display("FAIL fill1_est_start_cycle got=%0d exp=%0d", est_q[0], last_wr_cyc + 1);
      end
    end
    sample_valid = 1'b1; sample_data = 12'h5A5; exp_q.push_back({11'd0, 12'h5A5}); step();
    sample_valid = 1'b0; step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL fill1_write missing exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL fill1_write got=%h exp=%h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL fill1_extra_writes got=%0d exp=0", obs_q.size()); end
    enable = 1'b0; step(); step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL fill1_abort_busy got=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    exp_q.delete(); obs_q.delete(); est_q.delete(); est_mode = 1;
    enable = 1'b1; step(); step();
    fill_frame();
    sample_valid = 1'b0;
    for (int k = 0; k < 100 && est_q.size() < 3; k++) step();
    checks++;
    if (est_q.size() < 3) begin failures++; $display("FAIL tmo_pulses got=%0d exp=3", est_q.size()); end
    else begin
      checks++;
      if (est_q[0] != last_wr_cyc + 1) begin failures++; $display("FAIL tmo_first got=%0d exp=%0d", est_q[0], last_wr_cyc + 1); end
      checks++;
      if (est_q[1] - est_q[0] != 9) begin failures++; $display("FAIL tmo_period1 got=%0d exp=9", est_q[1] - est_q[0]); end
      checks++;
      if (est_q[2] - est_q[1] != 9) begin failures++; $display("FAIL tmo_period2 got=%0d exp=9", est_q[2] - est_q[1]); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL tmo_write missing exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL tmo_write got=%h exp=%h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL tmo_extra_writes got=%0d exp=0", obs_q.size()); end
    est_mode = 0; enable = 1'b0;
    for (int k = 0; k < 200 && frame_cnt != 16'd2; k++) step();
    step(); step();
    checks++;
    if (frame_cnt !== 16'd2) begin failures++; $display("FAIL tmo_frame_cnt got=%0d exp=2", frame_cnt); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL tmo_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_abort();
    exp_q.delete(); obs_q.delete(); est_q.delete();
    enable = 1'b1; step(); step();
    d0 = dropped; f0 = frame_cnt;
    for (int i = 0; i < 1000; i++) begin
      sample_valid = 1'b1;
      sample_data  = 12'((i * 3) & 12'hFFF);
      exp_q.push_back({11'(i), 12'((i * 3) & 12'hFFF)});
      step();
    end
    enable = 1'b0; sample_valid = 1'b1; sample_data = 12'h777; step();
    sample_valid = 1'b0; step(); step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++;
    if (frame_cnt !== 16'(f0)) begin failures++; $display("FAIL abort_frame_cnt got=%0d exp=%0d", frame_cnt, f0); end
    checks++;
    if (est_q.size() != 0) begin failures++; $display("FAIL abort_est_start got=%0d exp=0", est_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL abort_write missing exp=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL abort_write got=%h exp=%h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL abort_extra_writes got=%0d exp=0", obs_q.size()); end
    sample_valid = 1'b1; repeat (3) step(); sample_valid = 1'b0;
    checks++;
    if (dropped !== 16'(d0)) begin failures++; $display("FAIL abort_idle_dropped got=%0d exp=%0d", dropped, d0); end
    enable = 1'b1; step(); step();
    sample_valid = 1'b1; sample_data = 12'h123; exp_q.push_back({11'd0, 12'h123}); step();
    sample_valid = 1'b0; step();
    checks++;
    if (obs_q.size() != 1) begin failures++; $display("FAIL abort_reenable_count got=%0d exp=1", obs_q.size()); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL abort_reenable_write got=%h exp=%h", o, e); end
    end
    enable = 1'b0; step(); step();
  endtask

  task automatic test_decim4();
    exp4_q.delete(); obs4_q.delete(); est4_q.delete();
    en4 = 1'b1; step(); step();
    for (int i = 0; i < 8192; i++) begin
      v4 = 1'b1; d4 = i[11:0];
      if (i % 4 == 0) exp4_q.push_back({11'(i / 4), 12'((4 * (i / 4)) & 12'hFFF)});
      step();
    end
    v4 = 1'b0; en4 = 1'b0;
    repeat (5) step();
    checks++;
    if (est4_q.size() != 1) begin failures++; $display("FAIL dec4_est_start got=%0d exp=1", est4_q.size()); end
    while (exp4_q.size() > 0) begin
      e = exp4_q.pop_front(); checks++;
      if (obs4_q.size() == 0) begin failures++; $display("FAIL dec4_write missing exp=%h", e); end
      else begin
        o = obs4_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL dec4_write got=%h exp=%h", o, e); end
      end
    end
    checks++;
    if (obs4_q.size() != 0) begin failures++; $display("FAIL dec4_extra_writes got=%0d exp=0", obs4_q.size()); end
  endtask

  task automatic test_reset_wait_done();
    exp_q.delete(); obs_q.delete(); est_q.delete(); est_mode = 0; busy_len = 100;
    enable = 1'b1; step(); step();
    fill_frame();
    sample_valid = 1'b0;
    for (int k = 0; k < 50 && est_done !== 1'b0; k++) step();
    repeat (5) step();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
    exp_q.delete(); obs_q.delete();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({we, waddr, wdata, est_start, busy, frame_cnt, dropped} !== '0) begin
      failures++;
      $display("FAIL rst_async_outputs got=%h exp=0", {we, waddr, wdata, est_start, busy, frame_cnt, dropped});
    end
    checks++;
    if ({busy4, frame_cnt4, waddr4} !== '0) begin
      failures++; $display("FAIL rst_async_dec4 got=%h exp=0", {busy4, frame_cnt4, waddr4});
    end
    enable = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
    repeat (120) step();
    enable = 1'b1; step(); step();
    sample_valid = 1'b1; sample_data = 12'hBEE; exp_q.push_back({11'd0, 12'hBEE}); step();
    sample_valid = 1'b0; step();
    checks++;
    if (obs_q.size() != 1) begin failures++; $display("FAIL rst_first_write_count got=%0d exp=1", obs_q.size()); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL rst_first_write got=%h exp=%h", o, e); end
    end
    enable = 1'b0; step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_decim1();
    test_timeout();
    test_abort();
    test_decim4();
    test_reset_wait_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sample_frame_writer.md
SAMPLE_FRAME_WRITER -- requirements
Module: sample_frame_writer

Interface
REQ-001 Parameter DECIM, default 1, SHALL set the number of valid input samples per stored sample (legal range 1..255).
REQ-002 Parameter FRAME_LEN, default 2048, SHALL set the samples per frame; it equals the estimator buffer depth.
REQ-003 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 enable  input  1  SHALL be the level request for continuous frame capture.
REQ-006 sample_valid  input  1  SHALL be the single-cycle strobe qualifying sample_data.
REQ-007 sample_data  input  12  SHALL be the unsigned offset-binary ADC sample.
REQ-008 we  output  1  SHALL be the buffer write enable.
REQ-009 waddr  output  11  SHALL be the buffer write address.
REQ-010 wdata  output  12  SHALL be the buffer write data.
REQ-011 est_start  output  1  SHALL be the one-cycle start pulse to the pitch estimator.
REQ-012 est_done  input  1  SHALL be the estimator done level (high = idle/finished).
REQ-013 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-014 frame_cnt  output  16  SHALL count completed frames, wrapping.
REQ-015 dropped  output  16  SHALL count samples discarded while enable=1 and state is not FILL; saturates at 0xFFFF.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, START, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE -> FILL on enable=1; waddr counter and decimation counter SHALL clear on entry to FILL.
REQ-018 In FILL, each sample_valid increments the decimation counter; the sample at count 0 is kept, and the counter wraps at DECIM-1.
REQ-019 A kept sample accepted in cycle N SHALL produce we=1, wdata=sample_data, waddr=current address in cycle N+1, for exactly one cycle.
REQ-020 The address SHALL increment after each write; the write to address FRAME_LEN-1 SHALL move FSM to START in the same cycle as we.
REQ-021 START SHALL assert est_start for exactly one cycle, then go to WAIT_BUSY.
REQ-022 WAIT_BUSY SHALL wait for est_done=0 (estimator done lags start by up to 2 cycles), then go to WAIT_DONE.
REQ-023 WAIT_BUSY SHALL time out after 8 cycles with est_done still 1; it then returns to START and reissues est_start.
REQ-024 WAIT_DONE SHALL wait for est_done=1, increment frame_cnt, then go to FILL if enable=1, otherwise IDLE.
REQ-025 enable=0 during FILL SHALL abort the frame: go to IDLE next cycle with no est_start, and frame_cnt unchanged; a write already scheduled SHALL still complete.
REQ-026 enable=0 in START/WAIT_BUSY/WAIT_DONE SHALL NOT abort; the handshake SHALL complete, then go to IDLE.
REQ-027 sample_valid with enable=1 in START, WAIT_BUSY or WAIT_DONE SHALL increment dropped; samples in IDLE SHALL NOT be counted.
REQ-028 we SHALL never be asserted outside FILL or the cycle after the final FILL accept; the buffer is never written while the estimator reads it.
REQ-029 sample_data SHALL be written unmodified; sample_data is ignored when sample_valid=0.

Reset
REQ-030 On rst_n=0: state=IDLE, we=0, waddr=0, wdata=0, est_start=0, busy=0, frame_cnt=0, dropped=0, decimation counter=0; this applies immediately (asynchronous assertion).
REQ-031 Reset mid-frame SHALL discard the partial frame; the first frame after reset starts at address 0.
REQ-032 Reset release SHALL be synchronised so that all flops leave reset on the same clk edge.

Structure
REQ-033 Shared package f0_pkg SHALL hold SAMPLE_W=12, ADDR_W=11, FRAME_LEN=2048 and the writer state encoding.
REQ-034 The saturating 16-bit counter SHALL be a sub-module sat_counter, used for dropped.
REQ-035 Expected size is 150-250 lines of RTL, and all outputs SHALL be registered.

Verification
REQ-036 DECIM=1, enable=1, 2048 valid samples with value=index -> buffer[i]=i, est_start pulses once 1 cycle after the write to 2047, and waddr 0..2047 occurs in order.
REQ-037 DECIM=4, 8192 valid samples with value=index -> buffer[i]=4*i and exactly one est_start.
REQ-038 est_done model: low 2 cycles after start, high 100 cycles later; enable held -> frame_cnt=1, FILL re-entered, and valids during the wait raise dropped by the count sent.
REQ-039 est_done held 1 after start -> est_start reissued every 9 cycles, with no write activity.
REQ-040 enable dropped after 1000 writes -> IDLE, no est_start, and frame_cnt=0; re-enable -> next write at waddr=0.
REQ-041 rst_n asserted during WAIT_DONE -> all outputs 0 without a clock edge, and the FSM is in IDLE after release.
